// File: rtl/detector_sequencia_pkg.sv
// Shared types and constants for the serial pattern detector.
package detector_sequencia_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSCA  = 2'd1,
    ACHADO = 2'd2
  } estado_t;

  localparam logic MODO_PRIMEIRO = 1'b0;
  localparam logic MODO_CONTINUO = 1'b1;

endpackage

// File: rtl/detector_sequencia_if.sv
// Control, serial data and status bundle of the pattern detector.
interface detector_sequencia_if #(
  parameter int PALAVRA_W = 8,
  parameter int CONT_W    = 8
);
  logic                 setar_palavra;
  logic [PALAVRA_W-1:0] palavra;
  logic [PALAVRA_W-1:0] mascara;
  logic                 modo;
  logic                 sobreposicao;
  logic                 start;
  logic                 stop;
  logic                 bit_valid;
  logic                 bit_in;
  logic                 encontrado;
  logic                 ocupado;
  logic [CONT_W-1:0]    contagem;

  modport master (
    output setar_palavra, palavra, mascara, modo, sobreposicao,
           start, stop, bit_valid, bit_in,
    input  encontrado, ocupado, contagem
  );

  modport slave (
    input  setar_palavra, palavra, mascara, modo, sobreposicao,
           start, stop, bit_valid, bit_in,
    output encontrado, ocupado, contagem
  );
endinterface

// File: rtl/detector_sequencia_comparador.sv
// Masked equality: igual is high when every cared-for bit of dado equals palavra.
module comparador_mascarado #(
  parameter int PALAVRA_W = 8
) (
  input  logic [PALAVRA_W-1:0] dado_i,
  input  logic [PALAVRA_W-1:0] palavra_i,
  input  logic [PALAVRA_W-1:0] mascara_i,
  output logic                 igual_o
);
  logic [PALAVRA_W-1:0] diff;

  for (genvar gi = 0; gi < PALAVRA_W; gi++) begin : g_bit
    assign diff[gi] = (dado_i[gi] ^ palavra_i[gi]) & mascara_i[gi];
  end

  assign igual_o = ~|diff;
endmodule

// File: rtl/detector_sequencia.sv
// Serial pattern detector: shift window, masked compare, FSM and saturating match counter.
module detector_sequencia
  import detector_sequencia_pkg::*;
#(
  parameter int PALAVRA_W = 8,
  parameter int CONT_W    = 8
) (
  input logic            clk,
  input logic            rst_n,
  detector_sequencia_if.slave bus
);
  localparam int FILL_W = $clog2(PALAVRA_W + 1);
  localparam logic [FILL_W-1:0] FILL_CHEIO = FILL_W'(PALAVRA_W);

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_BUSCA  = 2'(BUSCA);
  localparam logic [1:0] S_ACHADO = 2'(ACHADO);

  logic [1:0]           state_q, state_d;
  logic [PALAVRA_W-1:0] shift_q, shift_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [PALAVRA_W-1:0] pal_q, pal_d;
  logic [PALAVRA_W-1:0] masc_q, masc_d;
  logic                 modo_q, modo_d;
  logic                 sobre_q, sobre_d;
  logic                 enc_q, enc_d;
  logic [CONT_W-1:0]    cnt_q, cnt_d;

  logic [PALAVRA_W-1:0] shift_next;
  logic [FILL_W-1:0]    fill_next;
  logic                 igual;
  logic                 hit;

  assign shift_next = {shift_q[PALAVRA_W-2:0], bus.bit_in};
  assign fill_next  = (fill_q == FILL_CHEIO) ? fill_q : fill_q + 1'b1;

  comparador_mascarado #(.PALAVRA_W(PALAVRA_W)) u_cmp (
    .dado_i    (shift_next),
    .palavra_i (pal_q),
    .mascara_i (masc_q),
    .igual_o   (igual)
  );

  // A full window is required, so a cleared all-zero register never matches by itself.
  assign hit = (fill_next == FILL_CHEIO) && igual;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    fill_d  = fill_q;
    pal_d   = pal_q;
    masc_d  = masc_q;
    modo_d  = modo_q;
    sobre_d = sobre_q;
    enc_d   = enc_q;
    cnt_d   = cnt_q;

    if (bus.stop) begin
      state_d = S_IDLE;
      enc_d   = 1'b0;
    end else if (bus.start) begin
      state_d = S_BUSCA;
      shift_d = '0;
      fill_d  = '0;
      enc_d   = 1'b0;
      cnt_d   = '0;
      modo_d  = bus.modo;
      sobre_d = bus.sobreposicao;
    end else if (state_q == S_BUSCA) begin
      if (modo_q == MODO_CONTINUO) enc_d = 1'b0;
      if (bus.bit_valid) begin
        shift_d = shift_next;
        fill_d  = fill_next;
        if (hit) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          enc_d = 1'b1;
          if (modo_q == MODO_PRIMEIRO) begin
            state_d = S_ACHADO;
          end else if (!sobre_q) begin
            shift_d = '0;
            fill_d  = '0;
          end
        end
      end
    end

    // The old word still judges this edge; the new one takes effect afterwards.
    if (bus.setar_palavra) begin
      pal_d  = bus.palavra;
      masc_d = bus.mascara;
      if (state_q == S_BUSCA) begin
        shift_d = '0;
        fill_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      fill_q  <= '0;
      pal_q   <= '0;
      masc_q  <= '1;
      modo_q  <= 1'b0;
      sobre_q <= 1'b0;
      enc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      fill_q  <= fill_d;
      pal_q   <= pal_d;
      masc_q  <= masc_d;
      modo_q  <= modo_d;
      sobre_q <= sobre_d;
      enc_q   <= enc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.encontrado = enc_q;
  assign bus.ocupado    = (state_q == S_BUSCA);
  assign bus.contagem   = cnt_q;
endmodule

// File: tb/tb_detector_sequencia.sv
// Self-checking bench: directed scenarios plus random traffic against a bit-history reference model.
module tb_detector_sequencia;
  localparam int W  = 8;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  detector_sequencia_if #(.PALAVRA_W(W), .CONT_W(CW)) bus ();

  detector_sequencia #(.PALAVRA_W(W), .CONT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: recent bits kept as a list, window rebuilt arithmetically.
  logic [W-1:0] m_pal, m_mask;
  bit           m_modo, m_sobre, m_enc;
  int           m_state;   // 0 idle, 1 searching, 2 holding match
  int           m_cnt;
  bit           hist[$];

  task automatic model_edge();
    int old_state;
    int win;
    bit is_hit;
    if (!rst_n) begin
      m_state = 0; m_pal = '0; m_mask = '1; m_modo = 0; m_sobre = 0;
      m_enc = 0; m_cnt = 0; hist.delete();
      return;
    end
    old_state = m_state;
    is_hit = 0;
    if (bus.stop) begin
      m_state = 0; m_enc = 0;
    end else if (bus.start) begin
      hist.delete(); m_enc = 0; m_cnt = 0;
      m_modo = bus.modo; m_sobre = bus.sobreposicao; m_state = 1;
    end else if (m_state == 1) begin
      if (m_modo) m_enc = 0;
      if (bus.bit_valid) begin
        hist.push_back(bus.bit_in);
        if (hist.size() > W) void'(hist.pop_front());
        if (hist.size() == W) begin
          win = 0;
          foreach (hist[i]) win = win * 2 + int'(hist[i]);
          is_hit = (((W'(win) ^ m_pal) & m_mask) == '0);
        end
        if (is_hit) begin
          m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
          m_enc = 1;
          if (!m_modo) m_state = 2;
          else if (!m_sobre) hist.delete();
        end
      end
    end
    if (bus.setar_palavra) begin
      m_pal = bus.palavra; m_mask = bus.mascara;
      if (old_state == 1) hist.delete();
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    bus.setar_palavra = 0; bus.start = 0; bus.stop = 0; bus.bit_valid = 0;
  endtask

  task automatic program_word(input logic [W-1:0] p, input logic [W-1:0] m);
    bus.setar_palavra = 1; bus.palavra = p; bus.mascara = m;
    tick();
  endtask

  task automatic begin_search(input bit modo, input bit sobre);
    bus.start = 1; bus.modo = modo; bus.sobreposicao = sobre;
    bus.bit_valid = 1; bus.bit_in = 1;   // bits on the start cycle are ignored
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rst_n = 0; bus.start = 1; bus.bit_valid = 1; bus.bit_in = 1;
      tick();
    end
    rst_n = 1;
    tests++;
    if (bus.encontrado !== 1'b0 || bus.ocupado !== 1'b0 || bus.contagem !== '0) begin
      fails++;
      $display("FAIL reset: got enc=%0b ocup=%0b cnt=%0d, want 0 0 0",
               bus.encontrado, bus.ocupado, bus.contagem);
    end
    $display("[TB] reset: enc=%0b ocup=%0b cnt=%0d", bus.encontrado, bus.ocupado, bus.contagem);
  endtask

  task automatic test_stop_on_first();
    logic [W-1:0] stream;
    stream = 8'hA5;
    program_word(8'hA5, 8'hFF);
    begin_search(0, 0);
    for (int i = 0; i < W + 4; i++) begin
      bus.bit_valid = 1;
      bus.bit_in = (i < W) ? stream[W-1-i] : 1'($urandom_range(0, 1));
      tick();
      tests++;
      if (bus.encontrado !== m_enc || bus.ocupado !== (m_state == 1) || int'(bus.contagem) != m_cnt) begin
        fails++;
        $display("FAIL stop_on_first bit%0d: got enc=%0b ocup=%0b cnt=%0d, want %0b %0b %0d",
                 i, bus.encontrado, bus.ocupado, bus.contagem, m_enc, m_state == 1, m_cnt);
      end
      if (i == W + 1) begin
        // a reset glitch between edges must not be seen
        #1 rst_n = 0;
        #1 rst_n = 1;
      end
    end
    tests++;
    if (bus.encontrado !== 1'b1 || bus.ocupado !== 1'b0 || bus.contagem !== 2'd1) begin
      fails++;
      $display("FAIL stop_on_first final: got enc=%0b ocup=%0b cnt=%0d, want 1 0 1",
               bus.encontrado, bus.ocupado, bus.contagem);
    end
    $display("[TB] stop_on_first: enc=%0b ocup=%0b cnt=%0d", bus.encontrado, bus.ocupado, bus.contagem);
  endtask

  task automatic test_fill_guard();
    program_word(8'h00, 8'hFF);
    begin_search(0, 0);
    for (int i = 0; i < 2 * W; i++) begin
      bus.bit_valid = (i % 2 == 0); bus.bit_in = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      tests++;
      if (bus.encontrado !== m_enc || int'(bus.contagem) != m_cnt) begin
        fails++;
        $display("FAIL fill_guard cyc%0d: got enc=%0b cnt=%0d, want %0b %0d",
                 i, bus.encontrado, bus.contagem, m_enc, m_cnt);
      end
      if (i == 2 * W - 4) begin
        tests++;
        if (bus.encontrado !== 1'b0) begin
          fails++;
          $display("FAIL fill_guard seven_zeros: got enc=%0b, want 0", bus.encontrado);
        end
      end
    end
    tests++;
    if (bus.encontrado !== 1'b1) begin
      fails++;
      $display("FAIL fill_guard eighth_zero: got enc=%0b, want 1", bus.encontrado);
    end
    $display("[TB] fill_guard: enc=%0b cnt=%0d", bus.encontrado, bus.contagem);
  endtask

  task automatic test_continuous(input bit sobre, input int want_cnt);
    int pulses;
    pulses = 0;
    program_word(8'hAA, 8'hFF);
    begin_search(1, sobre);
    for (int i = 0; i < 10; i++) begin
      bus.bit_valid = 1; bus.bit_in = (i % 2 == 0);
      tick();
      pulses += int'(bus.encontrado);
      tests++;
      if (bus.encontrado !== m_enc || int'(bus.contagem) != m_cnt || bus.ocupado !== 1'b1) begin
        fails++;
        $display("FAIL continuous sobre=%0b bit%0d: got enc=%0b cnt=%0d ocup=%0b, want %0b %0d 1",
                 sobre, i, bus.encontrado, bus.contagem, bus.ocupado, m_enc, m_cnt);
      end
    end
    tick();
    tests++;
    if (int'(bus.contagem) != want_cnt || pulses != want_cnt || bus.encontrado !== 1'b0) begin
      fails++;
      $display("FAIL continuous sobre=%0b final: got cnt=%0d pulses=%0d enc=%0b, want %0d %0d 0",
               sobre, bus.contagem, pulses, bus.encontrado, want_cnt, want_cnt);
    end
    $display("[TB] continuous sobre=%0b: cnt=%0d pulses=%0d", sobre, bus.contagem, pulses);
  endtask

  task automatic test_mask_saturation();
    logic [3:0] head;
    head = 4'b1010;
    program_word(8'hA0, 8'hF0);
    begin_search(1, 1);
    for (int i = 0; i < 12; i++) begin
      bus.bit_valid = 1; bus.bit_in = (i < 4) ? head[3-i] : 1'b1;
      tick();
      tests++;
      if (bus.encontrado !== m_enc || int'(bus.contagem) != m_cnt) begin
        fails++;
        $display("FAIL mask bit%0d: got enc=%0b cnt=%0d, want %0b %0d",
                 i, bus.encontrado, bus.contagem, m_enc, m_cnt);
      end
    end
    bus.setar_palavra = 1; bus.palavra = 8'h00; bus.mascara = 8'h00;
    tick();
    for (int i = 0; i < W + 3; i++) begin
      bus.bit_valid = 1; bus.bit_in = 1'($urandom_range(0, 1));
      tick();
      tests++;
      if (bus.encontrado !== m_enc || int'(bus.contagem) != m_cnt) begin
        fails++;
        $display("FAIL saturation bit%0d: got enc=%0b cnt=%0d, want %0b %0d",
                 i, bus.encontrado, bus.contagem, m_enc, m_cnt);
      end
    end
    tests++;
    if (bus.contagem !== 2'd3) begin
      fails++;
      $display("FAIL saturation final: got cnt=%0d, want 3", bus.contagem);
    end
    $display("[TB] mask_saturation: cnt=%0d", bus.contagem);
  endtask

  task automatic test_abort_restart();
    logic [W-1:0] pat;
    pat = 8'h3C;
    program_word(8'hFF, 8'hFF);
    begin_search(1, 1);
    for (int i = 0; i < 9; i++) begin
      bus.bit_valid = 1; bus.bit_in = 1;
      tick();
    end
    bus.stop = 1;
    tick();
    tests++;
    if (bus.ocupado !== 1'b0 || bus.encontrado !== 1'b0 || bus.contagem !== 2'd2) begin
      fails++;
      $display("FAIL abort: got ocup=%0b enc=%0b cnt=%0d, want 0 0 2",
               bus.ocupado, bus.encontrado, bus.contagem);
    end
    program_word(pat, 8'hFF);
    begin_search(0, 0);
    for (int i = 0; i < 5; i++) begin
      bus.bit_valid = 1; bus.bit_in = pat[W-1-i];
      tick();
    end
    bus.setar_palavra = 1; bus.palavra = pat; bus.mascara = 8'hFF;
    tick();
    for (int i = 0; i < W; i++) begin
      bus.bit_valid = 1; bus.bit_in = pat[W-1-i];
      tick();
      tests++;
      if (bus.encontrado !== m_enc || int'(bus.contagem) != m_cnt || bus.encontrado !== (i == W - 1)) begin
        fails++;
        $display("FAIL restart bit%0d: got enc=%0b cnt=%0d, want %0b %0d",
                 i, bus.encontrado, bus.contagem, m_enc, m_cnt);
      end
    end
    $display("[TB] abort_restart: enc=%0b cnt=%0d", bus.encontrado, bus.contagem);
  endtask

  task automatic test_random();
    logic [W-1:0] pats [4];
    int r;
    int hits;
    pats[0] = 8'hA5; pats[1] = 8'h00; pats[2] = 8'hFF; pats[3] = 8'h6B;
    hits = 0;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      rst_n = (r < 1) ? 1'b0 : 1'b1;
      bus.stop = (r >= 1 && r < 4);
      bus.start = (r >= 4 && r < 9) || (r == 99);
      bus.setar_palavra = (r >= 9 && r < 12) || (r == 98);
      bus.palavra = pats[$urandom_range(0, 3)];
      bus.mascara = W'($urandom & $urandom & $urandom);
      bus.modo = 1'($urandom_range(0, 1));
      bus.sobreposicao = 1'($urandom_range(0, 1));
      bus.bit_valid = ($urandom_range(0, 3) != 0);
      bus.bit_in = 1'($urandom_range(0, 1));
      tick();
      rst_n = 1;
      hits += int'(m_enc);
      tests++;
      if (bus.encontrado !== m_enc || bus.ocupado !== (m_state == 1) || int'(bus.contagem) != m_cnt) begin
        fails++;
        $display("FAIL random cyc%0d: got enc=%0b ocup=%0b cnt=%0d, want %0b %0b %0d",
                 i, bus.encontrado, bus.ocupado, bus.contagem, m_enc, m_state == 1, m_cnt);
      end
    end
    $display("[TB] random: 1500 cycles, %0d cycles with encontrado", hits);
  endtask

  initial begin
    bus.setar_palavra = 0; bus.palavra = '0; bus.mascara = '0; bus.modo = 0;
    bus.sobreposicao = 0; bus.start = 0; bus.stop = 0; bus.bit_valid = 0; bus.bit_in = 0;
    #1;
    test_reset();
    test_stop_on_first();
    test_fill_guard();
    test_continuous(1, 2);
    test_continuous(0, 1);
    test_mask_saturation();
    test_abort_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
